ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised EX/MEM pipeline stage for the pipelined CPU, sitting between the ALU and the data-memory/write-back path. It captures the ALU result, store data and control bits, and adds what the fixed 25-bit stage register lacks: configurable widths, a valid bit, flush, and store-data patching from write-back, both on capture and while the stage is stalled. It also keeps a saturating count of cycles the stage held a valid instruction.

## Interface
- DATA_W, 8: width of ALU result and store data
- ADDR_W, 3: register-file address width
- CNT_W, 16: stall-counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- enb  in  1  advance; load the stage from the I* inputs
- flush  in  1  kill the stage contents (bubble)
- Ivalid  in  1  incoming instruction is valid
- IaluResult, Ir2  in  DATA_W  ALU result, store data
- Idest, IR2Address  in  ADDR_W  destination register, source address of Ir2
- IDMMemWrite, IregWrite, IregWriteDataSel  in  1  control bits
- wb_regWrite  in  1  write-back stage is writing the register file
- wb_dest  in  ADDR_W  write-back destination
- wb_data  in  DATA_W  write-back data
- cnt_clr  in  1  synchronous clear of stall_count
- Ovalid  out  1  stage holds a valid instruction
- OaluResult, Or2  out  DATA_W  registered copies
- Odest, OR2Address  out  ADDR_W  registered copies
- ODMMemWrite, OregWrite, OregWriteDataSel  out  1  registered control bits
- stall_count  out  CNT_W  saturating held-cycle counter

## Operation
- Reset (rst=0, asynchronous): every output, including Ovalid and stall_count, goes to 0 immediately and stays 0 while rst=0.
- Per-edge priority: flush > enb > hold.
- Flush: all stage fields, including Ovalid, are cleared to 0. Control outputs are 0 whenever Ovalid=0.
- Load (enb=1, flush=0):
  - All I* fields are captured and Ovalid takes Ivalid.
  - If Ivalid=0, the control bits are stored as 0.
- Capture forwarding: on load, if wb_regWrite=1 and wb_dest==IR2Address, Or2 takes wb_data instead of Ir2. Register 0 gets no special handling.
- Hold (enb=0, flush=0): all fields are retained, except for hold patching.
- Hold patching: while held with Ovalid=1, if wb_regWrite=1 and wb_dest==OR2Address, Or2 takes wb_data at that edge. The register is re-checked on every held cycle, so the last matching write wins.
- Stall counter:
  - Increments by 1 on each edge where enb=0, flush=0 and Ovalid=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 sets it to 0 on the edge and overrides an increment in the same cycle.
  - Flush and load do not affect it.
- Widths: all comparisons are exact ADDR_W equality. There is no arithmetic on the data path.

## Timing
- Latency is one cycle from the inputs to the O* outputs. All outputs are registered, with no combinational input-to-output path.
- wb_* is sampled on the same edge as the load or hold decision. A write-back and a load to the same address in one cycle therefore gives the patched value one cycle later.
- Simultaneous flush and enb: flush wins and the instruction is lost.
- Simultaneous flush and hold patching: flush wins and Or2 becomes 0.
- Reset released mid-operation: the first edge with rst=1 behaves normally from the all-zero state (Ovalid=0, no count).
- Stalls while Ovalid=0 are not counted and perform no patching.

## Test plan
- Reset/load:
  - Stimulus: rst=0 with the inputs toggling, then release rst and load Ivalid=1, IaluResult=8'h3C, Ir2=8'h11, Idest=5, IR2Address=2, IDMMemWrite=1.
  - Response: all outputs are 0 during reset; one cycle after the load edge the outputs match the inputs and Ovalid=1.
- Capture forwarding:
  - Stimulus: load IR2Address=4, Ir2=8'hAA with wb_regWrite=1, wb_dest=4, wb_data=8'h55.
  - Response: Or2=8'h55. With wb_dest=3 instead, Or2=8'hAA.
- Hold patching:
  - Stimulus: hold a valid store (OR2Address=6, Or2=8'h01) for 3 cycles; write-back to r6 with 8'h77 in cycle 2 and 8'h78 in cycle 3.
  - Response: Or2=8'h77, then 8'h78; stall_count=3.
- Flush priority:
  - Stimulus: flush=1 and enb=1 on the same edge with Ivalid=1, IregWrite=1.
  - Response: all outputs are 0 and stall_count is unchanged.
- Counter saturation and clear:
  - Stimulus: CNT_W=3, hold valid for 10 cycles, then cnt_clr=1 while still holding.
  - Response: the count saturates at 7, then reads 0 after the clear edge and resumes at 1.
- Async reset mid-stall:
  - Stimulus: assert rst=0 between clock edges while holding valid with stall_count=5.
  - Response: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, store data and control with a valid bit,
// flush, write-back forwarding into the store data, and a saturating held-cycle counter.
module ex_mem_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              flush,
  input  logic              Ivalid,
  input  logic [DATA_W-1:0] IaluResult,
  input  logic [DATA_W-1:0] Ir2,
  input  logic [ADDR_W-1:0] Idest,
  input  logic [ADDR_W-1:0] IR2Address,
  input  logic              IDMMemWrite,
  input  logic              IregWrite,
  input  logic              IregWriteDataSel,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              cnt_clr,
  output logic              Ovalid,
  output logic [DATA_W-1:0] OaluResult,
  output logic [DATA_W-1:0] Or2,
  output logic [ADDR_W-1:0] Odest,
  output logic [ADDR_W-1:0] OR2Address,
  output logic              ODMMemWrite,
  output logic              OregWrite,
  output logic              OregWriteDataSel,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_valid_p1;
  logic [DATA_W-1:0] r_alu_p1;
  logic [DATA_W-1:0] r_r2_p1;
  logic [ADDR_W-1:0] r_dest_p1;
  logic [ADDR_W-1:0] r_r2addr_p1;
  logic              r_memwr_p1;
  logic              r_regwr_p1;
  logic              r_wdsel_p1;
  logic [CNT_W-1:0]  r_cnt;

  logic w_fwd_capture;
  logic w_patch_hold;
  logic w_held_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_fwd_capture = wb_regWrite && (wb_dest == IR2Address);
  assign w_patch_hold  = wb_regWrite && (wb_dest == r_r2addr_p1) && r_valid_p1;
  assign w_held_valid  = !enb && !flush && r_valid_p1;

  // Stage register: flush > load > hold (with store-data patching while held)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_p1  <= 1'b0;
      r_alu_p1    <= '0;
      r_r2_p1     <= '0;
      r_dest_p1   <= '0;
      r_r2addr_p1 <= '0;
      r_memwr_p1  <= 1'b0;
      r_regwr_p1  <= 1'b0;
      r_wdsel_p1  <= 1'b0;
    end else if (flush) begin
      r_valid_p1  <= 1'b0;
      r_alu_p1    <= '0;
      r_r2_p1     <= '0;
      r_dest_p1   <= '0;
      r_r2addr_p1 <= '0;
      r_memwr_p1  <= 1'b0;
      r_regwr_p1  <= 1'b0;
      r_wdsel_p1  <= 1'b0;
    end else if (enb) begin
      r_valid_p1  <= Ivalid;
      r_alu_p1    <= IaluResult;
      r_r2_p1     <= w_fwd_capture ? wb_data : Ir2;
      r_dest_p1   <= Idest;
      r_r2addr_p1 <= IR2Address;
      r_memwr_p1  <= Ivalid & IDMMemWrite;
      r_regwr_p1  <= Ivalid & IregWrite;
      r_wdsel_p1  <= Ivalid & IregWriteDataSel;
    end else if (w_patch_hold) begin
      r_r2_p1 <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_cnt <= '0;
    else if (cnt_clr)      r_cnt <= '0;
    else if (w_held_valid) r_cnt <= sat_inc(r_cnt);
  end

  assign Ovalid           = r_valid_p1;
  assign OaluResult       = r_alu_p1;
  assign Or2              = r_r2_p1;
  assign Odest            = r_dest_p1;
  assign OR2Address       = r_r2addr_p1;
  assign ODMMemWrite      = r_memwr_p1;
  assign OregWrite        = r_regwr_p1;
  assign OregWriteDataSel = r_wdsel_p1;
  assign stall_count      = r_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus hand-written multi-cycle sequences.
module tb_ex_mem_stage;

  logic       clk = 1'b0;
  logic       rst, enb, flush, Ivalid;
  logic [7:0] IaluResult, Ir2, wb_data;
  logic [2:0] Idest, IR2Address, wb_dest;
  logic       IDMMemWrite, IregWrite, IregWriteDataSel, wb_regWrite, cnt_clr;

  logic        Ovalid, ODMMemWrite, OregWrite, OregWriteDataSel;
  logic [7:0]  OaluResult, Or2;
  logic [2:0]  Odest, OR2Address;
  logic [15:0] stall_count;

  logic        Ovalid3, ODMMemWrite3, OregWrite3, OregWriteDataSel3;
  logic [7:0]  OaluResult3, Or23;
  logic [2:0]  Odest3, OR2Address3;
  logic [2:0]  stall_count3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(8), .ADDR_W(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .enb(enb), .flush(flush), .Ivalid(Ivalid),
    .IaluResult(IaluResult), .Ir2(Ir2), .Idest(Idest), .IR2Address(IR2Address),
    .IDMMemWrite(IDMMemWrite), .IregWrite(IregWrite), .IregWriteDataSel(IregWriteDataSel),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest), .wb_data(wb_data), .cnt_clr(cnt_clr),
    .Ovalid(Ovalid), .OaluResult(OaluResult), .Or2(Or2), .Odest(Odest),
    .OR2Address(OR2Address), .ODMMemWrite(ODMMemWrite), .OregWrite(OregWrite),
    .OregWriteDataSel(OregWriteDataSel), .stall_count(stall_count)
  );

  ex_mem_stage #(.DATA_W(8), .ADDR_W(3), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .enb(enb), .flush(flush), .Ivalid(Ivalid),
    .IaluResult(IaluResult), .Ir2(Ir2), .Idest(Idest), .IR2Address(IR2Address),
    .IDMMemWrite(IDMMemWrite), .IregWrite(IregWrite), .IregWriteDataSel(IregWriteDataSel),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest), .wb_data(wb_data), .cnt_clr(cnt_clr),
    .Ovalid(Ovalid3), .OaluResult(OaluResult3), .Or2(Or23), .Odest(Odest3),
    .OR2Address(OR2Address3), .ODMMemWrite(ODMMemWrite3), .OregWrite(OregWrite3),
    .OregWriteDataSel(OregWriteDataSel3), .stall_count(stall_count3)
  );

  typedef struct {
    logic       enb, flush, iv;
    logic [7:0] alu, r2;
    logic [2:0] dest, r2a;
    logic       mw, rw, sel;
    logic       wbrw;
    logic [2:0] wbd;
    logic [7:0] wbdata;
    logic [25:0] exp;
  } vec_t;

  vec_t tv[10];

  function automatic logic [25:0] pk(input logic v, input logic [7:0] alu, input logic [7:0] r2,
                                     input logic [2:0] d, input logic [2:0] a,
                                     input logic mw, input logic rw, input logic sel);
    return {v, alu, r2, d, a, mw, rw, sel};
  endfunction

  function automatic logic [25:0] outs();
    return {Ovalid, OaluResult, Or2, Odest, OR2Address, ODMMemWrite, OregWrite, OregWriteDataSel};
  endfunction

  function automatic logic [25:0] outs3();
    return {Ovalid3, OaluResult3, Or23, Odest3, OR2Address3, ODMMemWrite3, OregWrite3,
            OregWriteDataSel3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e, input logic f, input logic iv, input logic [7:0] alu,
                        input logic [7:0] r2, input logic [2:0] d, input logic [2:0] a,
                        input logic mw, input logic rw, input logic sel,
                        input logic wrw, input logic [2:0] wd, input logic [7:0] wdat);
    enb = e; flush = f; Ivalid = iv; IaluResult = alu; Ir2 = r2; Idest = d; IR2Address = a;
    IDMMemWrite = mw; IregWrite = rw; IregWriteDataSel = sel;
    wb_regWrite = wrw; wb_dest = wd; wb_data = wdat;
  endtask

  task automatic hold(input logic wrw, input logic [2:0] wd, input logic [7:0] wdat);
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, wrw, wd, wdat);
  endtask

  initial begin
    tv[0] = '{1,0,1, 8'h3C,8'h11, 3'd5,3'd2, 1,0,0, 0,3'd0,8'h00, pk(1,8'h3C,8'h11,3'd5,3'd2,1,0,0)};
    tv[1] = '{1,0,1, 8'h10,8'hAA, 3'd1,3'd4, 0,1,1, 1,3'd4,8'h55, pk(1,8'h10,8'h55,3'd1,3'd4,0,1,1)};
    tv[2] = '{1,0,1, 8'h20,8'hAA, 3'd2,3'd4, 0,1,0, 1,3'd3,8'h55, pk(1,8'h20,8'hAA,3'd2,3'd4,0,1,0)};
    tv[3] = '{1,0,0, 8'h33,8'h44, 3'd7,3'd1, 1,1,1, 0,3'd0,8'h00, pk(0,8'h33,8'h44,3'd7,3'd1,0,0,0)};
    tv[4] = '{0,0,1, 8'hFF,8'hFF, 3'd0,3'd0, 1,1,1, 1,3'd1,8'h99, pk(0,8'h33,8'h44,3'd7,3'd1,0,0,0)};
    tv[5] = '{1,1,1, 8'h66,8'h77, 3'd3,3'd3, 0,1,0, 0,3'd0,8'h00, 26'h0};
    tv[6] = '{1,0,1, 8'h5A,8'h0F, 3'd3,3'd0, 0,1,0, 1,3'd0,8'hE1, pk(1,8'h5A,8'hE1,3'd3,3'd0,0,1,0)};
    tv[7] = '{0,0,0, 8'h00,8'h00, 3'd0,3'd0, 0,0,0, 1,3'd0,8'hC3, pk(1,8'h5A,8'hC3,3'd3,3'd0,0,1,0)};
    tv[8] = '{0,0,0, 8'h00,8'h00, 3'd0,3'd0, 0,0,0, 0,3'd0,8'hFF, pk(1,8'h5A,8'hC3,3'd3,3'd0,0,1,0)};
    tv[9] = '{0,1,0, 8'h00,8'h00, 3'd0,3'd0, 0,0,0, 1,3'd0,8'hBB, 26'h0};

    // Reset held with inputs toggling
    rst = 1'b0; cnt_clr = 1'b0;
    set_in(1, 0, 1, 8'hA5, 8'h5A, 3'd6, 3'd6, 1, 1, 1, 1, 3'd6, 8'hEE);
    #1;
    chk("reset_outs", {outs(), stall_count}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(i[0], 0, ~i[0], 8'hF0 ^ 8'(i), 8'h0F, 3'(i), 3'(i+1), 1, 1, 1, 1, 3'(i+1), 8'h77);
      step();
      chk("reset_hold", {outs(), stall_count, outs3(), stall_count3}, 64'h0);
    end
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      set_in(tv[i].enb, tv[i].flush, tv[i].iv, tv[i].alu, tv[i].r2, tv[i].dest, tv[i].r2a,
             tv[i].mw, tv[i].rw, tv[i].sel, tv[i].wbrw, tv[i].wbd, tv[i].wbdata);
      step();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tv[i].exp));
    end
    chk("table_count", 64'(stall_count), 64'd2);

    // Hold patching over three held cycles, last write wins
    set_in(1, 0, 1, 8'h42, 8'h01, 3'd2, 3'd6, 1, 0, 0, 0, 3'd0, 8'h00);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("patch_load", 64'(outs()), 64'(pk(1, 8'h42, 8'h01, 3'd2, 3'd6, 1, 0, 0)));
    hold(0, 3'd0, 8'h00); step();
    chk("patch_c1", 64'(Or2), 64'h01);
    hold(1, 3'd6, 8'h77); step();
    chk("patch_c2", 64'(Or2), 64'h77);
    hold(1, 3'd6, 8'h78); step();
    chk("patch_c3", {outs(), stall_count}, {pk(1, 8'h42, 8'h78, 3'd2, 3'd6, 1, 0, 0), 16'd3});

    // Flush and enb on the same edge
    set_in(1, 1, 1, 8'h99, 8'h88, 3'd4, 3'd4, 0, 1, 0, 1, 3'd4, 8'h12);
    step();
    chk("flush_prio", {outs(), stall_count}, {26'h0, 16'd3});

    // Saturation on the 3-bit counter, then clear while holding
    set_in(1, 0, 1, 8'h01, 8'h02, 3'd1, 3'd2, 0, 1, 0, 0, 3'd0, 8'h00);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_start", {stall_count, 13'h0, stall_count3}, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      hold(0, 3'd0, 8'h00);
      step();
      if (i == 6 || i == 7 || i == 10)
        chk($sformatf("sat_c%0d", i), {stall_count, 13'h0, stall_count3},
            {16'(i), 13'h0, 3'(i > 7 ? 7 : i)});
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_clear", {stall_count, 13'h0, stall_count3}, 32'h0);
    step();
    chk("sat_resume", {stall_count, 13'h0, stall_count3}, {16'd1, 13'h0, 3'd1});

    // Asynchronous reset between edges while holding with count 5
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_async", {outs(), stall_count}, {pk(1, 8'h01, 8'h02, 3'd1, 3'd2, 0, 1, 0), 16'd5});
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst", {outs(), stall_count, outs3(), stall_count3}, 64'h0);
    #1;
    rst = 1'b1;
    step();
    chk("post_rst_hold", {outs(), stall_count}, 42'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
